cybercobra_hex_display: RTL and testbench

Output stage downstream of the CYBERcobra core: takes the 32-bit `out_o` result word and shows it as eight hexadecimal digits on the board's multiplexed, common-anode 7-segment display. It snapshots the word once per full scan so digits never tear mid-scan. It drives one digit at a time, with a one-cycle blanking gap between digits to suppress ghosting. Pure sink: no back-pressure to the core.

---
 rtl/cybercobra_hex_display.sv | 126 ++++++++++++
 tb/tb_cybercobra_hex_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cybercobra_hex_display.sv
// -----------------------------------------------------------------------------
// cybercobra_hex_display
//
// Shows the 32-bit CYBERcobra result word as eight hexadecimal digits on a
// multiplexed, common-anode 7-segment display. One digit is driven at a time.
// Each digit slot lasts REFRESH_DIV cycles: one blank cycle (anodes all off,
// suppresses ghosting while segments settle) followed by REFRESH_DIV-1 lit
// cycles. The word is snapshotted once per full scan so a scan never shows a
// mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Ports:
//   clk_i   in   system clock, rising edge
//   rst_i   in   asynchronous active-high reset
//   data_i  in   [31:0] word to display (CYBERcobra out_o)
//   hold_i  in   1 = freeze the snapshot at the scan boundary
//   an_o    out  [7:0] digit anodes, active-low, bit k = hex digit k
//   seg_o   out  [6:0] segments, active-low, bit 0 = a ... bit 6 = g
//
// Optional feature macro:
//   HEX_LZB_EN   leading-zero blanking (digits above the most significant
//                non-zero nibble stay dark; digit 0 is always lit)
//
// Interface protocol: pure sink, no valid/ready. data_i is sampled only on a
// snapshot edge; no back-pressure is ever applied to the core.
// -----------------------------------------------------------------------------
module cybercobra_hex_display #(
    parameter int REFRESH_DIV = 10000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int            PW     = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

    // Hex nibble to active-low segments, bit order g..a.
    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [PW-1:0] p_q, p_d;
    logic [2:0]    d_q, d_d;
    logic [31:0]   snap_q, snap_d;
    logic          prime_q, prime_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          p_last;
    logic          lit;
    logic [3:0]    nibble;
`ifdef HEX_LZB_EN
    logic          upper_zero;
`endif

    always_comb begin
        p_last  = (p_q == P_LAST);
        p_d     = p_last ? '0 : p_q + 1'b1;
        d_d     = p_last ? d_q + 3'd1 : d_q;

        // prime forces one unconditional load on the first edge after reset
        // so the display does not sit on zero for a whole scan.
        prime_d = 1'b0;
        snap_d  = snap_q;
        if (prime_q || (p_last && (d_q == 3'd7) && !hold_i)) begin
            snap_d = data_i;
        end

        nibble  = snap_q[{d_q, 2'b00} +: 4];
        lit     = (p_q != '0);
`ifdef HEX_LZB_EN
        // Everything at and above this digit is zero: keep it dark.
        upper_zero = (d_q != 3'd0) && ((snap_q >> {d_q, 2'b00}) == 32'd0);
        lit        = lit && !upper_zero;
`endif
        an_d    = lit ? ~(8'h01 << d_q) : 8'hFF;
        seg_d   = dec(nibble);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q     <= '0;
            d_q     <= 3'd0;
            snap_q  <= 32'd0;
            prime_q <= 1'b1;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            p_q     <= p_d;
            d_q     <= d_d;
            snap_q  <= snap_d;
            prime_q <= prime_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_cybercobra_hex_display.sv
// -----------------------------------------------------------------------------
// tb_cybercobra_hex_display
//
// Directed bench for cybercobra_hex_display with REFRESH_DIV = 4. A timeline
// model indexed by the number of edges since reset release predicts the anode
// and segment values for each cycle; predictions are queued before the edge
// and popped against the registered outputs one time unit after it.
// -----------------------------------------------------------------------------
module tb_cybercobra_hex_display;

    localparam int RD   = 4;
    localparam int SCAN = 8 * RD;

    logic        clk;
    logic        rst_i;
    logic [31:0] data_i;
    logic        hold_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;

    cybercobra_hex_display #(.REFRESH_DIV(RD)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .data_i (data_i),
        .hold_i (hold_i),
        .an_o   (an_o),
        .seg_o  (seg_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference decoder, bits g..a
    logic [6:0] dec_tab [16];
    initial begin
        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
        dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001;
        dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;
    end

    // scoreboard
    logic [14:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          k        = 0;      // edges since reset release
    logic [31:0] shown    = 32'd0;  // word the display is expected to hold

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
            $error("%s", tag);
        end
    endtask

    // One clock: predict, clock, compare, advance the timeline.
    task automatic step();
        int          pp;
        int          dd;
        logic [7:0]  an_e;
        logic [6:0]  seg_e;
        logic        load;
        logic [31:0] nxt;
        logic [14:0] e;
        pp    = k % RD;
        dd    = (k / RD) % 8;
        an_e  = (pp == 0) ? 8'hFF : ~(8'h01 << dd);
`ifdef HEX_LZB_EN
        if (pp != 0 && dd != 0 && (shown >> (4 * dd)) == 32'd0) an_e = 8'hFF;
`endif
        seg_e = dec_tab[(shown >> (4 * dd)) & 32'hF];
        exp_q.push_back({an_e, seg_e});
        load  = (k == 0) || (pp == RD - 1 && dd == 7 && !hold_i);
        nxt   = data_i;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("an", {24'd0, an_o}, {24'd0, e[14:7]});
        check("seg", {25'd0, seg_o}, {25'd0, e[6:0]});
        if (load) shown = nxt;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the next edge will be at digit dd, prescaler pp.
    task automatic run_to(input int dd, input int pp);
        int guard;
        guard = 0;
        while (!((k % RD) == pp && ((k / RD) % 8) == dd) && guard < 2 * SCAN) begin
            step();
            guard++;
        end
        check("run_to_bound", guard < 2 * SCAN, 1);
    endtask

    initial begin
        rst_i  = 1'b1;
        data_i = 32'h0000_00E5;
        hold_i = 1'b0;

        // reset held for 3 cycles: all dark
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_an", {24'd0, an_o}, 32'h0000_00FF);
            check("rst_seg", {25'd0, seg_o}, 32'h0000_007F);
        end
        rst_i = 1'b0;
        k     = 0;
        shown = 32'd0;

        // first edge: blank; second edge: digit 0 shows "5"
        step();
        check("first_blank", {24'd0, an_o}, 32'h0000_00FF);
        step();
        check("first_lit_an", {24'd0, an_o}, 32'h0000_00FE);
        check("first_lit_seg", {25'd0, seg_o}, 32'h0000_0012);
        run(SCAN * 2 - 2);

        // decoder sweep, all 16 codes on their anodes
        data_i = 32'h7654_3210;
        run(SCAN * 2);
        data_i = 32'hFEDC_BA98;
        run(SCAN * 2);

        // change while digit 3 is lit: no tearing
        data_i = 32'h1111_1111;
        run(SCAN);
        run_to(3, 2);
        data_i = 32'h2222_2222;
        run(SCAN * 2);

        // hold across a scan boundary
        data_i = 32'h0000_0001;
        run(SCAN);
        hold_i = 1'b1;
        data_i = 32'h0000_0002;
        run(SCAN * 2);
        check("hold_kept", shown, 32'h0000_0001);
        hold_i = 1'b0;
        run(SCAN * 2);
        check("hold_released", shown, 32'h0000_0002);

        // asynchronous reset mid-slot on digit 5
        data_i = 32'h89AB_CDEF;
        run(SCAN);
        run_to(5, 2);
        step();
        #2;
        rst_i = 1'b1;
        #1;
        check("async_an", {24'd0, an_o}, 32'h0000_00FF);
        check("async_seg", {25'd0, seg_o}, 32'h0000_007F);
        @(posedge clk);
        #1;
        check("async_hold_an", {24'd0, an_o}, 32'h0000_00FF);
        rst_i = 1'b0;
        k     = 0;
        shown = 32'd0;
        step();
        step();
        check("restart_an", {24'd0, an_o}, 32'h0000_00FE);
        check("restart_seg", {25'd0, seg_o}, 32'h0000_000E);
        run(SCAN);

        // leading zeros
        data_i = 32'h0000_0A00;
        run(SCAN * 2);
        data_i = 32'h0000_0000;
        run(SCAN * 2);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
